// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the FSM state encoding, the supported requester count and a grant helper.
package memory_arbiter_pkg;

  localparam int unsigned NUM_REQ_C = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_e;

  // Turn a requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ_C-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_arbiter.sv
// Combinational round-robin winner selection between two requesters.
// The requester not granted last wins a tie; a lone requester always wins.
module rr_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_C
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               grant_idx_o
);

  always_comb begin
    grant_idx_o = 1'b0;
    grant_o     = '0;
    if (valid_i[0] && valid_i[1]) begin
      grant_idx_o = ~last_grant_i;
    end else if (valid_i[1]) begin
      grant_idx_o = 1'b1;
    end
    if (|valid_i) begin
      grant_o = idx_to_onehot(grant_idx_o);
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// One transaction in flight: accept in IDLE, one ISSUE cycle, RD_WAIT for reads only.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = NUM_REQ_C
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0]               req_rw_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
  output logic                             mem_en_o,
  output logic                             mem_rw_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
  output logic                             busy_o
);

  arb_state_e              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_grant_q, last_grant_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_rw_q, mem_rw_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    busy_q, busy_d;

  logic [NUM_REQ-1:0]      grant;
  logic                    grant_idx;
  logic                    accept;
  logic                    sel_rw;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .valid_i      (req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  // Accept only from IDLE and never while reset is being applied.
  assign accept      = (state_q == IDLE) && !rst && (|req_valid_i);
  assign req_ready_o = accept ? grant : '0;

  always_comb begin
    sel_rw    = grant_idx ? req_rw_i[1] : req_rw_i[0];
    sel_addr  = grant_idx ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                          : req_addr_i[ADDR_WIDTH-1:0];
    sel_wdata = grant_idx ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                          : req_wdata_i[DATA_WIDTH-1:0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_en_d     = 1'b0;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          mem_en_d     = 1'b1;
          mem_rw_d     = sel_rw;
          mem_addr_d   = sel_addr;
          mem_wdata_d  = sel_wdata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_rw_q) begin
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = IDLE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        rsp_rdata_d          = mem_rdata_i;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_en_q     <= mem_en_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_rw_o    = mem_rw_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter attached to a small synchronous memory model.
// A transaction-level reference predicts grants, latencies and read data per cycle.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  req_rw_i;
  logic [3:0]  req_addr_i;
  logic [15:0] req_wdata_i;
  logic [1:0]  rsp_valid_o;
  logic [7:0]  rsp_rdata_o;
  logic        mem_en_o;
  logic        mem_rw_o;
  logic [1:0]  mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  memory_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_REQ(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_rw_i    (req_rw_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .mem_en_o    (mem_en_o),
    .mem_rw_o    (mem_rw_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Memory: write on enable, read data registered one edge after enable.
  logic [7:0] mem [4];
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_rw_o) mem[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i     <= mem[mem_addr_o];
    end
  end

  // Reference: at most one transaction in flight, described by its event cycles.
  int         cyc = 0;
  int         free_at = 0, acc_at = -1, en_at = -1, pulse_at = -1;
  bit         m_last = 1'b1;
  bit         p_idx = 1'b0, p_read = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       m_rw = 1'b0;
  logic [1:0] m_addr = 2'b00;
  logic [7:0] m_wdata = 8'h00, m_rdata = 8'h00;
  logic [7:0] ref_mem [4];
  int         e_win;
  logic [1:0] e_ready, e_rsp;
  logic       e_en, e_busy;
  logic [7:0] e_rdata;
  bit         pend = 1'b0;

  task automatic model_eval();
    e_win = -1;
    if (!rst && cyc >= free_at && req_valid_i != 2'b00) begin
      if (req_valid_i == 2'b11) e_win = m_last ? 0 : 1;
      else                      e_win = req_valid_i[0] ? 0 : 1;
    end
    e_ready = (e_win < 0) ? 2'b00 : ((e_win == 0) ? 2'b01 : 2'b10);
    e_en    = (cyc == en_at);
    e_rsp   = (cyc == pulse_at) ? (p_idx ? 2'b10 : 2'b01) : 2'b00;
    e_rdata = (cyc == pulse_at && p_read) ? p_data : m_rdata;
    e_busy  = (cyc > acc_at) && (cyc < free_at);
  endtask

  task automatic model_commit();
    logic [1:0] ad;
    logic [7:0] wdv;
    logic       rwv;
    if (cyc == pulse_at && p_read) m_rdata = p_data;
    if (rst) begin
      free_at = cyc + 1; acc_at = cyc; en_at = -1; pulse_at = -1;
      m_last = 1'b1; m_rw = 1'b0; m_addr = 2'b00; m_wdata = 8'h00; m_rdata = 8'h00;
    end else if (e_win >= 0) begin
      rwv = (e_win == 1) ? req_rw_i[1] : req_rw_i[0];
      ad  = (e_win == 1) ? req_addr_i[3:2] : req_addr_i[1:0];
      wdv = (e_win == 1) ? req_wdata_i[15:8] : req_wdata_i[7:0];
      acc_at = cyc; en_at = cyc + 1;
      m_rw = rwv; m_addr = ad; m_wdata = wdv;
      m_last = (e_win == 1); p_idx = (e_win == 1); p_read = !rwv;
      if (rwv) begin
        ref_mem[ad] = wdv; pulse_at = cyc + 2; free_at = cyc + 2;
      end else begin
        p_data = ref_mem[ad]; pulse_at = cyc + 3; free_at = cyc + 3;
      end
    end
    cyc++;
  endtask

  // Advance one cycle: retire the previous cycle in the model, drive, settle, predict.
  task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] rw,
                       input logic [3:0] a, input logic [15:0] wd);
    if (pend) model_commit();
    @(negedge clk);
    rst = r; req_valid_i = v; req_rw_i = rw; req_addr_i = a; req_wdata_i = wd;
    #1;
    model_eval();
    pend = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 2'b00, 4'h0, 16'h0000);
  endtask

  // One request from requester idx held until accepted, then wait for its completion.
  task automatic do_txn(input bit idx, input logic rw, input logic [1:0] addr,
                        input logic [7:0] wd, output int acc_c, output int rsp_c,
                        output logic [1:0] vec, output logic [7:0] rd);
    logic [1:0] v;
    v = idx ? 2'b10 : 2'b01;
    acc_c = -1; rsp_c = -1; vec = 2'b00; rd = 8'h00;
    for (int k = 0; k < 10 && acc_c < 0; k++) begin
      drive(1'b0, v, {rw, rw}, {addr, addr}, {wd, wd});
      if (req_ready_o[idx]) acc_c = cyc;
    end
    for (int k = 0; k < 8 && rsp_c < 0 && acc_c >= 0; k++) begin
      drive(1'b0, 2'b00, 2'b00, 4'h0, 16'h0000);
      if (rsp_valid_o[idx]) begin
        rsp_c = cyc; vec = rsp_valid_o; rd = rsp_rdata_o;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b11, 2'b00, 4'b0110, 16'h1234);
      total++;
      if (req_ready_o !== 2'b00) begin
        bad++; $display("FAIL reset_ready got=%b exp=00", req_ready_o);
      end
      total++;
      if (rsp_valid_o !== 2'b00 || rsp_rdata_o !== 8'h00 || busy_o !== 1'b0) begin
        bad++; $display("FAIL reset_rsp got=%b/%h/%b exp=00/00/0", rsp_valid_o, rsp_rdata_o, busy_o);
      end
      total++;
      if ({mem_en_o, mem_rw_o, mem_addr_o, mem_wdata_o} !== 12'h000) begin
        bad++; $display("FAIL reset_mem got=%b %b %h %h exp=0", mem_en_o, mem_rw_o, mem_addr_o, mem_wdata_o);
      end
    end
    drive(1'b0, 2'b11, 2'b00, 4'b0110, 16'h1234);
    total++;
    if (req_ready_o !== 2'b01 || req_ready_o !== e_ready) begin
      bad++; $display("FAIL first_grant got=%b exp=01 model=%b", req_ready_o, e_ready);
    end
    drive(1'b0, 2'b00, 2'b00, 4'h0, 16'h0000);
    total++;
    if (mem_en_o !== 1'b1 || busy_o !== 1'b1 || mem_addr_o !== 2'd2) begin
      bad++; $display("FAIL first_issue got=en%b busy%b addr%0d exp=en1 busy1 addr2", mem_en_o, busy_o, mem_addr_o);
    end
    idle(3);
  endtask

  task automatic test_write_read();
    int a0, r0, a1, r1;
    logic [1:0] v0, v1;
    logic [7:0] d0, d1;
    do_txn(1'b0, 1'b1, 2'd2, 8'hA5, a0, r0, v0, d0);
    total++;
    if (a0 < 0 || r0 - a0 != 2 || v0 !== 2'b01) begin
      bad++; $display("FAIL wr_latency got=%0d vec=%b exp=2 vec=01", r0 - a0, v0);
    end
    do_txn(1'b1, 1'b0, 2'd2, 8'h00, a1, r1, v1, d1);
    total++;
    if (a1 < 0 || r1 - a1 != 3 || v1 !== 2'b10) begin
      bad++; $display("FAIL rd_latency got=%0d vec=%b exp=3 vec=10", r1 - a1, v1);
    end
    total++;
    if (d1 !== 8'hA5 || d1 !== e_rdata) begin
      bad++; $display("FAIL rd_data got=%h exp=a5 model=%h", d1, e_rdata);
    end
  endtask

  task automatic test_back_to_back();
    idle(1);
    drive(1'b0, 2'b01, 2'b01, 4'b0011, 16'h00FF);
    total++;
    if (req_ready_o !== 2'b01) begin
      bad++; $display("FAIL b2b_wr_accept got=%b exp=01", req_ready_o);
    end
    drive(1'b0, 2'b01, 2'b00, 4'b0011, 16'h0000);
    total++;
    if (req_ready_o !== 2'b00 || mem_en_o !== 1'b1 || mem_rw_o !== 1'b1 ||
        mem_addr_o !== 2'd3 || mem_wdata_o !== 8'hFF) begin
      bad++; $display("FAIL b2b_wr_issue got=rdy%b en%b rw%b a%0d d%h exp=rdy00 en1 rw1 a3 dff",
                      req_ready_o, mem_en_o, mem_rw_o, mem_addr_o, mem_wdata_o);
    end
    drive(1'b0, 2'b01, 2'b00, 4'b0011, 16'h0000);
    total++;
    if (rsp_valid_o !== 2'b01 || req_ready_o !== 2'b01) begin
      bad++; $display("FAIL b2b_ack_accept got=rsp%b rdy%b exp=rsp01 rdy01", rsp_valid_o, req_ready_o);
    end
    drive(1'b0, 2'b00, 2'b00, 4'h0, 16'h0000);
    total++;
    if (mem_en_o !== 1'b1 || mem_rw_o !== 1'b0 || mem_addr_o !== 2'd3) begin
      bad++; $display("FAIL b2b_rd_issue got=en%b rw%b a%0d exp=en1 rw0 a3", mem_en_o, mem_rw_o, mem_addr_o);
    end
    drive(1'b0, 2'b00, 2'b00, 4'h0, 16'h0000);
    total++;
    if (rsp_valid_o !== 2'b00 || mem_en_o !== 1'b0 || mem_addr_o !== 2'd3) begin
      bad++; $display("FAIL b2b_rd_wait got=rsp%b en%b a%0d exp=rsp00 en0 a3", rsp_valid_o, mem_en_o, mem_addr_o);
    end
    drive(1'b0, 2'b00, 2'b00, 4'h0, 16'h0000);
    total++;
    if (rsp_valid_o !== 2'b01 || rsp_rdata_o !== 8'hFF) begin
      bad++; $display("FAIL b2b_rd_done got=rsp%b d%h exp=rsp01 dff", rsp_valid_o, rsp_rdata_o);
    end
  endtask

  task automatic test_fairness();
    int  gq[$];
    int  n0, n1;
    bit  seq_ok, prev_en;
    drive(1'b1, 2'b00, 2'b00, 4'h0, 16'h0000);
    prev_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 2'b11, 2'b00, 4'b1001, 16'h0000);
      total++;
      if (req_ready_o !== e_ready) begin
        bad++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, req_ready_o, e_ready);
      end
      total++;
      if (mem_en_o && prev_en) begin
        bad++; $display("FAIL rr_en_consecutive cyc=%0d got=1 exp=0", i);
      end
      prev_en = mem_en_o;
      if (req_ready_o == 2'b01) gq.push_back(0);
      else if (req_ready_o == 2'b10) gq.push_back(1);
    end
    n0 = 0; n1 = 0;
    seq_ok = (gq.size() == 4);
    foreach (gq[k]) begin
      if (gq[k] == 0) n0++; else n1++;
      if (gq[k] != k % 2) seq_ok = 1'b0;
    end
    total++;
    if (!seq_ok || n0 != 2 || n1 != 2) begin
      bad++; $display("FAIL rr_sequence got=accepts%0d r0=%0d r1=%0d exp=accepts4 r0=2 r1=2 order0101",
                      gq.size(), n0, n1);
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    idle(1);
    drive(1'b0, 2'b01, 2'b00, 4'b0001, 16'h0000);
    total++;
    if (req_ready_o !== 2'b01) begin
      bad++; $display("FAIL mid_accept got=%b exp=01", req_ready_o);
    end
    drive(1'b1, 2'b11, 2'b00, 4'b0001, 16'h0000);
    total++;
    if (mem_en_o !== 1'b1 || req_ready_o !== 2'b00) begin
      bad++; $display("FAIL mid_issue got=en%b rdy%b exp=en1 rdy00", mem_en_o, req_ready_o);
    end
    drive(1'b0, 2'b11, 2'b00, 4'b0001, 16'h0000);
    total++;
    if (mem_en_o !== 1'b0 || rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
      bad++; $display("FAIL mid_after got=en%b rsp%b busy%b exp=en0 rsp00 busy0", mem_en_o, rsp_valid_o, busy_o);
    end
    total++;
    if (req_ready_o !== 2'b01) begin
      bad++; $display("FAIL mid_regrant got=%b exp=01", req_ready_o);
    end
    drive(1'b0, 2'b00, 2'b00, 4'h0, 16'h0000);
    total++;
    if (rsp_valid_o !== 2'b00) begin
      bad++; $display("FAIL mid_no_pulse got=%b exp=00", rsp_valid_o);
    end
    idle(4);
  endtask

  task automatic test_write_hold();
    int a, r;
    logic [1:0] v;
    logic [7:0] d, held;
    idle(1);
    held = e_rdata;
    do_txn(1'b1, 1'b1, 2'd0, 8'h3C, a, r, v, d);
    total++;
    if (a < 0 || r - a != 2 || v !== 2'b10 || d !== held || mem[0] !== 8'h3C) begin
      bad++; $display("FAIL hold_wr1 got=lat%0d vec%b d%h mem%h exp=lat2 vec10 d%h mem3c", r - a, v, d, mem[0], held);
    end
    drive(1'b0, 2'b00, 2'b00, 4'h0, 16'h0000);
    total++;
    if (rsp_valid_o !== 2'b00) begin
      bad++; $display("FAIL hold_pulse1 got=%b exp=00", rsp_valid_o);
    end
    do_txn(1'b1, 1'b1, 2'd0, 8'h00, a, r, v, d);
    total++;
    if (a < 0 || r - a != 2 || v !== 2'b10 || d !== held || d !== e_rdata || mem[0] !== 8'h00) begin
      bad++; $display("FAIL hold_wr2 got=lat%0d vec%b d%h mem%h exp=lat2 vec10 d%h mem00", r - a, v, d, mem[0], held);
    end
    drive(1'b0, 2'b00, 2'b00, 4'h0, 16'h0000);
    total++;
    if (rsp_valid_o !== 2'b00 || rsp_rdata_o !== held) begin
      bad++; $display("FAIL hold_pulse2 got=%b d%h exp=00 d%h", rsp_valid_o, rsp_rdata_o, held);
    end
  endtask

  task automatic test_random();
    bit prev_en = 1'b0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), 2'($urandom), 2'($urandom),
            4'($urandom), 16'($urandom));
      total++;
      if (req_ready_o !== e_ready) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready_o, e_ready);
      end
      total++;
      if (rsp_valid_o !== e_rsp || rsp_rdata_o !== e_rdata) begin
        bad++; $display("FAIL rnd_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, rsp_valid_o, rsp_rdata_o, e_rsp, e_rdata);
      end
      total++;
      if (mem_en_o !== e_en || busy_o !== e_busy || mem_rw_o !== m_rw ||
          mem_addr_o !== m_addr || mem_wdata_o !== m_wdata) begin
        bad++; $display("FAIL rnd_mem cyc=%0d got=en%b busy%b rw%b a%0d d%h exp=en%b busy%b rw%b a%0d d%h",
                        cyc, mem_en_o, busy_o, mem_rw_o, mem_addr_o, mem_wdata_o,
                        e_en, e_busy, m_rw, m_addr, m_wdata);
      end
      total++;
      if (mem_en_o && prev_en) begin
        bad++; $display("FAIL rnd_en_consecutive cyc=%0d got=1 exp=0", cyc);
      end
      prev_en = mem_en_o;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem[i]     = 8'(i * 37 + 5);
      ref_mem[i] = 8'(i * 37 + 5);
    end
    rst = 1'b1; req_valid_i = 2'b11; req_rw_i = 2'b00;
    req_addr_i = 4'b0110; req_wdata_i = 16'h1234;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_fairness();
    test_reset_mid();
    test_write_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 2, which sets the memory address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, which sets the memory data width.
REQ-003 The block SHALL have parameter NUM_REQ, default 2, which sets the number of requesters; the only supported value is 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid_i, input, NUM_REQ bits: per-requester request valid.
REQ-007 The block SHALL have port req_ready_o, output, NUM_REQ bits: per-requester accept, one-hot or zero.
REQ-008 The block SHALL have port req_rw_i, input, NUM_REQ bits: per-requester direction, 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr_i, input, NUM_REQ x ADDR_WIDTH: per-requester address.
REQ-010 The block SHALL have port req_wdata_i, input, NUM_REQ x DATA_WIDTH: per-requester write data.
REQ-011 The block SHALL have port rsp_valid_o, output, NUM_REQ bits: per-requester one-cycle completion pulse, for both reads and writes.
REQ-012 The block SHALL have port rsp_rdata_o, output, DATA_WIDTH: read data, valid when a read completion pulses.
REQ-013 The block SHALL have port mem_en_o, output, 1 bit: memory enable.
REQ-014 The block SHALL have port mem_rw_o, output, 1 bit: memory direction.
REQ-015 The block SHALL have port mem_addr_o, output, ADDR_WIDTH: memory address.
REQ-016 The block SHALL have port mem_wdata_o, output, DATA_WIDTH: memory write data.
REQ-017 The block SHALL have port mem_rdata_i, input, DATA_WIDTH: memory read data, registered by the memory one edge after the enable.
REQ-018 The block SHALL have port busy_o, output, 1 bit: asserted when the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, ISSUE and RD_WAIT.
REQ-020 In IDLE with any req_valid_i set, the block SHALL assert combinationally req_ready_o for the round-robin winner only, register that requester's rw, addr and wdata and its index as owner, and move to ISSUE.
REQ-021 req_ready_o SHALL be all-zero outside IDLE.
REQ-022 req_ready_o SHALL be all-zero in IDLE when no request is valid.
REQ-023 Round-robin: the requester not granted last SHALL win when both are valid; a lone valid requester SHALL win regardless of history; the last-grant register SHALL update only on an accept.
REQ-024 ISSUE SHALL drive mem_en_o=1 with the registered rw, addr and wdata for exactly one cycle.
REQ-025 From ISSUE, a write SHALL go to IDLE and register rsp_valid_o[owner]=1, so the pulse appears in the next cycle.
REQ-026 From ISSUE, a read SHALL go to RD_WAIT.
REQ-027 In RD_WAIT, the block SHALL register rsp_rdata_o<=mem_rdata_i and rsp_valid_o[owner]=1, then go to IDLE.
REQ-028 Latency SHALL be measured from the accept in cycle T: mem_en_o is high in T+1, a write completion pulses in T+2, a read completion pulses in T+3.
REQ-029 A new accept SHALL be possible in the same cycle as a completion pulse, giving 2-cycle write and 3-cycle read throughput.
REQ-030 Responses SHALL NOT be backpressured.
REQ-031 rsp_valid_o SHALL be a one-cycle pulse, at most one bit set.
REQ-032 rsp_rdata_o SHALL hold its last value between reads and SHALL NOT change on write completions.
REQ-033 mem_en_o SHALL be 0 in IDLE and RD_WAIT.
REQ-034 mem_addr_o, mem_rw_o and mem_wdata_o SHALL hold their last value while mem_en_o is 0.
REQ-035 The address SHALL be passed through unmodified; all 2**ADDR_WIDTH addresses, including the maximum, are legal.
REQ-036 A requester SHALL hold req_valid_i and its fields stable until req_ready_o is seen; the block does not depend on this for its own correctness.

Reset
REQ-037 rst SHALL be sampled only at the rising edge of clk.
REQ-038 On reset, state SHALL be IDLE, and all outputs registered or FSM-derived SHALL be 0 (mem_*_o, rsp_valid_o, rsp_rdata_o, busy_o).
REQ-039 On reset, the last-grant register SHALL point to requester 1, so that requester 0 wins the first contention.
REQ-040 Reset asserted mid-operation SHALL abandon the transaction: no completion pulse is produced and mem_en_o is 0 in the following cycle.
REQ-041 Memory contents SHALL NOT be touched by arbiter reset.
REQ-042 req_ready_o SHALL be 0 while rst is high.

Structure
REQ-043 Package memory_arbiter_pkg SHALL hold the state enum arb_state_e {IDLE, ISSUE, RD_WAIT} and the constant NUM_REQ_C = 2.
REQ-044 Winner selection SHALL be a separate combinational sub-module rr_arbiter (inputs: valid vector and last grant; outputs: one-hot grant and index).
REQ-045 All state and output registers SHALL live in memory_arbiter.

Verification (ADDR_WIDTH=2, DATA_WIDTH=8, arbiter connected to the memory)
REQ-046 Release reset with both requesters valid -> all outputs are 0 during reset, and req_ready_o=01 in the first IDLE cycle.
REQ-047 Req0 writes addr 2, data 0xA5, then req1 reads addr 2 -> rsp_valid_o=10 and rsp_rdata_o=0xA5 three cycles after req1's accept.
REQ-048 Both requesters valid continuously for 12 cycles with reads -> grants alternate 0,1,0,1; 4 accepts total, 2 per requester; mem_en_o never high in two consecutive cycles.
REQ-049 Req0 alone writes addr 3 data 0xFF, then reads addr 3 -> write ack at T+2, read accept at T+2, rsp_rdata_o=0xFF at T+5.
REQ-050 Assert rst in the ISSUE cycle of a read -> no rsp_valid_o pulse, mem_en_o=0 in the next cycle, and the next contention is granted to requester 0.
REQ-051 Req1 writes 0x3C to addr 0, then req1 writes 0x00 -> rsp_rdata_o keeps its prior value and rsp_valid_o=10 pulses exactly once per write.
